i2c_target_apb: RTL
===================

// Module: i2c_target_apb
// PURPOSE
//  APB-programmable I2C target (slave) controller: the responder counterpart of the APB I2C master.
//  Recognises its own 7-bit address, receives write bytes into an RX FIFO and answers reads from a TX FIFO.
//  Has the same masked-interrupt register set (RIS/IM/MIS) as the master, plus ICR. Sits on the peripheral APB bus.
// PARAMETERS
//  FIFO_DEPTH    16     RX and TX FIFO depth in bytes; power of 2, 2..256.
//  DEFAULT_ADDR  7'h50  Own-address register value at reset.
// PORTS
//  PCLK       in   1   Single clock for the APB and I2C logic.
//  PRESETn    in   1   Asynchronous, active-low reset.
//  PSEL       in   1   APB select.
//  PENABLE    in   1   APB enable (access phase).
//  PWRITE     in   1   APB write.
//  PADDR      in   32  APB address. Only [15:0] is decoded.
//  PWDATA     in   32  APB write data.
//  PREADY     out  1   Tied 1: zero wait states.
//  PRDATA     out  32  APB read data. Unmapped offsets return 32'hDEADBEEF.
//  scl_i      in   1   SCL line input.
//  scl_o      out  1   Tied 0: open-drain.
//  scl_oen_o  out  1   1 = release SCL, 0 = pull SCL low. Reset value 1.
//  sda_i      in   1   SDA line input.
//  sda_o      out  1   Tied 0: open-drain.
//  sda_oen_o  out  1   1 = release SDA, 0 = pull SDA low. Reset value 1.
//  i2c_irq    out  1   Interrupt: |MIS. Reset value 0.
// BEHAVIOUR
//  Registers. An access occurs when PSEL&PENABLE is high.
//   0x000 DATA: a write pushes PWDATA[7:0] into TX; a read pops RX.
//   0x004 ADDR[6:0]; 0x008 CTRL[0]=EN (reset 0).
//   0x00C STATUS {busy, txfull, txempty, rxfull, rxempty}.
//   0xF04 RIS; 0xF08 IM (reset 0); 0xF0C MIS = RIS&IM.
//   0xF10 ICR: write 1 to clear sticky bits.
//  RIS bits:
//   [0] RXNE  level
//   [1] TXE   level
//   [2] AMATCH sticky
//   [3] STOP  sticky
//   [4] RXOVF sticky
//   [5] TXUNF sticky
//   [6] MNACK sticky
//  Boundary and bus rules:
//   - A write to a full TX FIFO is dropped. A read of an empty RX FIFO returns 0 and pops nothing.
//   - When a sticky event and an ICR clear of the same bit happen in one cycle, the event wins.
//   - scl_i and sda_i pass through a 2-FF synchroniser. Edges are detected on the synchronised values.
//   - START (or repeated START) is SDA falling while SCL is high. STOP is SDA rising while SCL is high.
//   - SCL rising edge samples SDA. SCL falling edge updates sda_oen_o.
//  FSM:
//   - IDLE -> ADDR on START. ADDR shifts 8 bits.
//   - If EN=1 and addr[7:1]==ADDR: drive ACK, set AMATCH, then go to RX (R/W=0) or TX (R/W=1).
//     Otherwise release SDA and go to IDLE.
//   - RX: shift 8 bits, then ACK_RX. If RX is not full: push the byte and ACK.
//     If RX is full: NACK, discard the byte, set RXOVF. Then return to RX.
//   - TX: on the falling edge after the ACK, pop TX into the shifter and drive MSB first.
//     After the 8th bit, release SDA and sample the master's bit at the 9th SCL rise:
//     ACK -> TX continues; NACK -> set MNACK and go to IDLE.
//   - Any START goes to ADDR. Any STOP goes to IDLE, sets STOP and releases both lines within 1 cycle.
//   - Each ACK/NACK is held from the falling edge after bit 8 to the falling edge after bit 9.
//  busy=1 from START to STOP. A reset mid-transfer releases both lines immediately.
// CONFIGURATION
//  I2C_TGT_CLK_STRETCH_EN:
//   - Defined: a TX byte is due and TX is empty -> pull scl_oen_o=0 (STRETCH state).
//     Release SCL the cycle after a TX push. TXUNF never sets.
//     A STOP or START seen while stretching goes to IDLE or ADDR as usual.
//   - Undefined: never drive SCL. On underflow send 8'hFF and set TXUNF.
// STRUCTURE
//  Include file i2c_tgt_defs.vh holds register offsets, RIS bit indices and FSM state encodings (localparams).
//  Sub-module i2c_tgt_fifo: synchronous 8-bit FIFO, DEPTH param, push/pop/full/empty/level.
//  It is instantiated twice, for RX and TX.
// TESTING
//  1. ADDR=0x50, EN=1; master writes 0xA0,0x11,0x22,STOP -> ACKs on all bytes; RX pops 0x11,0x22; AMATCH,STOP set.
//  2. Master addresses 0x51 -> address NACKed; no FIFO change; AMATCH stays 0; state returns to IDLE.
//  3. TX preloaded 0x5A,0xC3; master reads 0xA1 with ACK then NACK -> bus returns 0x5A,0xC3; MNACK set.
//  4. FIFO_DEPTH=16; master writes 17 data bytes -> 17th NACKed; RXOVF=1; rxfull=1; after ICR 0x10, RXOVF=0.
//  5. TX empty on read: with the macro, SCL is held low until DATA=0x77 is written, then 0x77 is received.
//     Without it, 0xFF is received and TXUNF=1.
//  6. IM=0x08, STOP occurs -> i2c_irq=1. Repeated START mid-write -> ADDR phase restarts.
//     PRESETn low mid-byte -> both oen=1, IM=0, irq=0.

Source files
------------

// File: rtl/i2c_target_apb_pkg.sv
// Shared definitions for the APB I2C target: register offsets,
// interrupt bit positions and FSM state encodings.
package i2c_target_apb_pkg;

  localparam logic [15:0] OFF_DATA   = 16'h000;
  localparam logic [15:0] OFF_ADDR   = 16'h004;
  localparam logic [15:0] OFF_CTRL   = 16'h008;
  localparam logic [15:0] OFF_STATUS = 16'h00C;
  localparam logic [15:0] OFF_RIS    = 16'hF04;
  localparam logic [15:0] OFF_IM     = 16'hF08;
  localparam logic [15:0] OFF_MIS    = 16'hF0C;
  localparam logic [15:0] OFF_ICR    = 16'hF10;

  localparam int RIS_RXNE   = 0;
  localparam int RIS_TXE    = 1;
  localparam int RIS_AMATCH = 2;
  localparam int RIS_STOP   = 3;
  localparam int RIS_RXOVF  = 4;
  localparam int RIS_TXUNF  = 5;
  localparam int RIS_MNACK  = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_AACK,
    S_RX,
    S_RACK,
    S_TX,
    S_TACK,
    S_STRETCH
  } state_t;

endpackage

// File: rtl/i2c_tgt_fifo.sv
// Synchronous byte FIFO; pushes when full and pops when
// empty are ignored.
module i2c_tgt_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [7:0]             wdata,
  input  logic                   pop,
  output logic [7:0]             rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/i2c_target_apb.sv
// APB-programmable I2C target with RX/TX FIFOs and masked IRQs.
// Define I2C_TGT_CLK_STRETCH_EN to stretch SCL on TX underflow.
module i2c_target_apb
  import i2c_target_apb_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [6:0]  DEFAULT_ADDR = 7'h50
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  input  logic        scl_i,
  output logic        scl_o,
  output logic        scl_oen_o,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_oen_o,
  output logic        i2c_irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0] off;
  logic        acc;
  logic        wr;
  logic        rd;

  logic [6:0]  own_addr;
  logic        en;
  logic [6:0]  im;
  logic [6:2]  sticky;
  logic [6:2]  icr_clr;
  logic [6:0]  ris;

  logic        rx_push;
  logic        rx_pop;
  logic [7:0]  rx_dout;
  logic        rx_full;
  logic        rx_empty;
  logic [LW-1:0] rx_level;
  logic        tx_push;
  logic        tx_pop;
  logic [7:0]  tx_dout;
  logic        tx_full;
  logic        tx_empty;
  logic [LW-1:0] tx_level;

  logic        scl_m, scl_s, scl_q;
  logic        sda_m, sda_s, sda_q;
  logic        scl_rise, scl_fall;
  logic        start_det, stop_det;

  state_t      state;
  logic [7:0]  shreg;
  logic [3:0]  bitcnt;
  logic        rw;
  logic        busy;
  logic        sda_oen;
  logic        scl_oen;
  logic [6:2]  ev;
  logic        load_req;

  logic        unused_bits;

  assign off = PADDR[15:0];
  assign acc = PSEL & PENABLE;
  assign wr  = acc & PWRITE;
  assign rd  = acc & ~PWRITE;

  assign PREADY    = 1'b1;
  assign scl_o     = 1'b0;
  assign sda_o     = 1'b0;
  assign scl_oen_o = scl_oen;
  assign sda_oen_o = sda_oen;

  assign tx_push = wr & (off == OFF_DATA);
  assign rx_pop  = rd & (off == OFF_DATA);
  assign icr_clr = (wr && off == OFF_ICR) ? PWDATA[6:2] : '0;

  assign unused_bits = ^{PADDR[31:16], PWDATA[31:8],
                         rx_level, tx_level};

  i2c_tgt_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .push  (rx_push),
    .wdata (shreg),
    .pop   (rx_pop),
    .rdata (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  i2c_tgt_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .push  (tx_push),
    .wdata (PWDATA[7:0]),
    .pop   (tx_pop),
    .rdata (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      scl_q <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_m <= scl_i;
      scl_s <= scl_m;
      scl_q <= scl_s;
      sda_m <= sda_i;
      sda_s <= sda_m;
      sda_q <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  // Fall after an ACK on the read path: next byte is due.
  assign load_req = scl_fall &
                    ((state == S_AACK && rw) || state == S_TACK);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      rw      <= 1'b0;
      busy    <= 1'b0;
      sda_oen <= 1'b1;
      scl_oen <= 1'b1;
      rx_push <= 1'b0;
      tx_pop  <= 1'b0;
      ev      <= '0;
    end else begin
      rx_push <= 1'b0;
      tx_pop  <= 1'b0;
      ev      <= '0;
      if (stop_det) begin
        state        <= S_IDLE;
        sda_oen      <= 1'b1;
        scl_oen      <= 1'b1;
        busy         <= 1'b0;
        ev[RIS_STOP] <= 1'b1;
      end else if (start_det) begin
        state   <= S_ADDR;
        bitcnt  <= '0;
        sda_oen <= 1'b1;
        scl_oen <= 1'b1;
        busy    <= 1'b1;
      end else if (load_req) begin
        bitcnt <= '0;
        if (!tx_empty) begin
          shreg   <= tx_dout;
          sda_oen <= tx_dout[7];
          tx_pop  <= 1'b1;
          state   <= S_TX;
        end else begin
`ifdef I2C_TGT_CLK_STRETCH_EN
          scl_oen <= 1'b0;
          sda_oen <= 1'b1;
          state   <= S_STRETCH;
`else
          shreg         <= 8'hFF;
          sda_oen       <= 1'b1;
          ev[RIS_TXUNF] <= 1'b1;
          state         <= S_TX;
`endif
        end
      end else begin
        unique case (state)
          S_IDLE: ;
          S_ADDR, S_RX: begin
            if (scl_rise) begin
              shreg  <= {shreg[6:0], sda_s};
              bitcnt <= bitcnt + 4'd1;
            end else if (scl_fall && bitcnt == 4'd8) begin
              if (state == S_ADDR) begin
                if (en && shreg[7:1] == own_addr) begin
                  sda_oen        <= 1'b0;
                  ev[RIS_AMATCH] <= 1'b1;
                  rw             <= shreg[0];
                  state          <= S_AACK;
                end else begin
                  sda_oen <= 1'b1;
                  state   <= S_IDLE;
                end
              end else begin
                if (!rx_full) begin
                  rx_push <= 1'b1;
                  sda_oen <= 1'b0;
                end else begin
                  ev[RIS_RXOVF] <= 1'b1;
                  sda_oen       <= 1'b1;
                end
                state <= S_RACK;
              end
            end
          end
          S_AACK, S_RACK: begin
            if (scl_fall) begin
              sda_oen <= 1'b1;
              bitcnt  <= '0;
              state   <= S_RX;
            end
          end
          S_TX: begin
            if (scl_rise) begin
              bitcnt <= bitcnt + 4'd1;
            end else if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                sda_oen <= 1'b1;
                state   <= S_TACK;
              end else begin
                shreg   <= {shreg[6:0], 1'b0};
                sda_oen <= shreg[6];
              end
            end
          end
          S_TACK: begin
            if (scl_rise && sda_s) begin
              ev[RIS_MNACK] <= 1'b1;
              state         <= S_IDLE;
            end
          end
`ifdef I2C_TGT_CLK_STRETCH_EN
          S_STRETCH: begin
            if (!tx_empty) begin
              shreg   <= tx_dout;
              sda_oen <= tx_dout[7];
              tx_pop  <= 1'b1;
              scl_oen <= 1'b1;
              bitcnt  <= '0;
              state   <= S_TX;
            end
          end
`endif
          default: begin
            sda_oen <= 1'b1;
            scl_oen <= 1'b1;
            state   <= S_IDLE;
          end
        endcase
      end
    end
  end

  // An event in the same cycle as its ICR clear stays set.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      own_addr <= DEFAULT_ADDR;
      en       <= 1'b0;
      im       <= '0;
      sticky   <= '0;
    end else begin
      sticky <= (sticky & ~icr_clr) | ev;
      if (wr && off == OFF_ADDR) own_addr <= PWDATA[6:0];
      if (wr && off == OFF_CTRL) en <= PWDATA[0];
      if (wr && off == OFF_IM)   im <= PWDATA[6:0];
    end
  end

  always_comb begin
    ris           = '0;
    ris[6:2]      = sticky;
    ris[RIS_RXNE] = ~rx_empty;
    ris[RIS_TXE]  = tx_empty;
  end

  assign i2c_irq = |(ris & im);

  always_comb begin
    PRDATA = 32'hDEADBEEF;
    case (off)
      OFF_DATA:   PRDATA = {24'h0, rx_empty ? 8'h00 : rx_dout};
      OFF_ADDR:   PRDATA = {25'h0, own_addr};
      OFF_CTRL:   PRDATA = {31'h0, en};
      OFF_STATUS: PRDATA = {27'h0, busy, tx_full, tx_empty,
                            rx_full, rx_empty};
      OFF_RIS:    PRDATA = {25'h0, ris};
      OFF_IM:     PRDATA = {25'h0, im};
      OFF_MIS:    PRDATA = {25'h0, ris & im};
      default:    PRDATA = 32'hDEADBEEF;
    endcase
  end

endmodule
